// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and helpers for the digit-serial subtractor.
//   - serial_sub_state_t : control FSM states (IDLE, RUN, DONE)
//   - cnt_width()        : width of the digit counter for N digits per operation
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_sub_state_t;

    // At least one bit so a single-digit build (N == 1) still has a counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// -----------------------------------------------------------------------------
// full_sub_digit
//   Combinational DIGIT-bit full subtractor: {bo, d} = a_dig - b_dig - bi.
//   At DIGIT = 1 this is the classic bit-level full subtractor.
// Ports
//   a_dig  in  DIGIT  minuend digit
//   b_dig  in  DIGIT  subtrahend digit
//   bi     in  1      borrow in
//   d      out DIGIT  difference digit
//   bo     out 1      borrow out (1 = a_dig < b_dig + bi)
// -----------------------------------------------------------------------------
module full_sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    // One extra bit: a negative result shows up as a set MSB, which is the borrow.
    logic [DIGIT:0] diff;

    assign diff = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, bi};
    assign d    = diff[DIGIT-1:0];
    assign bo   = diff[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Digit-serial subtractor: dif = (a - b - bin) mod 2^WIDTH, bor = (a < b + bin).
//   DIGIT bits are processed per clock, LSB digit first, with a registered borrow
//   rippling between digits; N = WIDTH/DIGIT cycles per operation.
//   Build option: define SERIAL_SUB_SAT_EN for saturating mode (dif forced to 0
//   whenever the final borrow is set; bor still reports 1).
// Parameters
//   WIDTH  operand/result width (multiple of DIGIT)
//   DIGIT  bits subtracted per cycle
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled in IDLE or DONE only
//   a      in   WIDTH  minuend, latched on accepted start
//   b      in   WIDTH  subtrahend, latched on accepted start
//   bin    in   1      borrow in, latched on accepted start
//   busy   out  1      high while an operation is running
//   done   out  1      one-cycle pulse, dif/bor valid
//   dif    out  WIDTH  difference, held until next done
//   bor    out  1      final borrow out, held until next done
// -----------------------------------------------------------------------------
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             bor
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    serial_sub_state_t state, state_nxt;

    logic             accept;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] dif_nxt;
    logic             br;
    logic [DIGIT-1:0] d_dig;
    logic             bo_dig;

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // DONE lasts exactly one cycle, so done is a single-cycle pulse.
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- digit datapath
    full_sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_dig (a_sr[DIGIT-1:0]),
        .b_dig (b_sr[DIGIT-1:0]),
        .bi    (br),
        .d     (d_dig),
        .bo    (bo_dig)
    );

    // Digit k lands in result slice k; on the last digit this is the full result,
    // so the output register can be loaded in the same edge.
    always_comb begin
        res_full = res_sr;
        for (int k = 0; k < N; k++) begin
            if (cnt == CNT_W'(k)) begin
                res_full[k*DIGIT +: DIGIT] = d_dig;
            end
        end
    end

`ifdef SERIAL_SUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_dif(input logic [WIDTH-1:0] d,
                                                 input logic             b);
        return b ? '0 : d;
    endfunction

    assign dif_nxt = sat_dif(res_full, bo_dig);
`else
    assign dif_nxt = res_full;
`endif

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            dif    <= '0;
            bor    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_full;
            br     <= bo_dig;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                dif <= dif_nxt;
                bor <= bo_dig;
            end
        end
    end

endmodule
